// File: rtl/led_pkg.sv
// led_pkg: shared constants, FSM state type and helpers for the LED scheduler.
//   NSRC    number of pattern sources (2-bit indices)
//   LED_W   width of one LED pattern
//   state_t scheduler FSM state
//   onehot4 index -> one-hot grant vector
package led_pkg;

   localparam int NSRC  = 4;
   localparam int LED_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_t;

   function automatic logic [NSRC-1:0] onehot4(input logic [1:0] idx);
      onehot4      = '0;
      onehot4[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/led_scheduler_if.sv
// led_scheduler_if: bundle between the pattern sources and the LED scheduler.
//   src_req     per-source display request (level)
//   src_led     packed patterns, source i in [8i+7:8i]
//   hold        freeze the dwell counter
//   force_en    override arbitration with force_sel
//   force_sel   forced source index
//   grant       one-hot grant to the displayed source, zero when none
//   grant_start one-cycle pulse on each new or renewed grant
//   active_idx  index of the granted source (meaningful when grant != 0)
//   led         registered LED drive
//   busy        high while blanking or showing
//   dbg_state   scheduler FSM state, for observation only
//
// Handshake: src_req[i] is a level request that a source holds for as long as
// it wants display time; the scheduler answers with grant[i], which stays high
// for the whole dwell. grant_start marks the first cycle of every grant
// (including a renewal of the same source). Dropping src_req[i] while granted
// releases the grant on the next clock unless force_en is high.
interface led_scheduler_if;
   import led_pkg::*;

   logic [NSRC-1:0]       src_req;
   logic [NSRC*LED_W-1:0] src_led;
   logic                  hold;
   logic                  force_en;
   logic [1:0]            force_sel;
   logic [NSRC-1:0]       grant;
   logic                  grant_start;
   logic [1:0]            active_idx;
   logic [LED_W-1:0]      led;
   logic                  busy;
   state_t                dbg_state;

   modport master (
      output src_req, src_led, hold, force_en, force_sel,
      input  grant, grant_start, active_idx, led, busy, dbg_state
   );

   modport slave (
      input  src_req, src_led, hold, force_en, force_sel,
      output grant, grant_start, active_idx, led, busy, dbg_state
   );

endinterface

// File: rtl/led_rr_pick.sv
// led_rr_pick: combinational source picker.
//   i_req       request vector
//   i_last_idx  most recently granted index (round-robin pointer)
//   i_force_en  force selection of i_force_sel regardless of requests
//   i_force_sel forced index
//   o_valid     a pick exists
//   o_idx       picked index
module led_rr_pick
   import led_pkg::*;
(
   input  logic [NSRC-1:0] i_req,
   input  logic [1:0]      i_last_idx,
   input  logic            i_force_en,
   input  logic [1:0]      i_force_sel,
   output logic            o_valid,
   output logic [1:0]      o_idx
);

   logic [1:0] w_cand;

   always_comb begin
      o_valid = 1'b0;
      o_idx   = 2'd0;
      w_cand  = 2'd0;
      if (i_force_en) begin
         o_valid = 1'b1;
         o_idx   = i_force_sel;
      end else begin
         // Scan from farthest to nearest so the first requester after
         // i_last_idx is the last one written; 2-bit add wraps modulo 4.
         for (int k = NSRC; k >= 1; k--) begin
            w_cand = i_last_idx + 2'(k);
            if (i_req[w_cand]) begin
               o_valid = 1'b1;
               o_idx   = w_cand;
            end
         end
      end
   end

endmodule

// File: rtl/led_scheduler.sv
// led_scheduler: time-shares the LED bank between four pattern sources.
//   clk   system clock
//   rst_n asynchronous active-low reset
//   bus   led_scheduler_if.slave (requests/patterns in, grant/LED drive out)
// Parameters:
//   DWELL_CYC cycles a granted source is shown (>= 1)
//   BLANK_CYC cycles LEDs are dark between different sources (0 = no gap)
module led_scheduler
   import led_pkg::*;
#(
   parameter int DWELL_CYC = 25_000_000,
   parameter int BLANK_CYC = 1_000_000
) (
   input logic           clk,
   input logic           rst_n,
   led_scheduler_if.slave bus
);

   localparam int MAXC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] DWELL_LD = CW'(DWELL_CYC - 1);
   localparam logic [CW-1:0] BLANK_LD = (BLANK_CYC > 0) ? CW'(BLANK_CYC - 1) : '0;
   localparam bit NO_BLANK = (BLANK_CYC == 0);

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [1:0]       r_last_idx;
   logic [1:0]       r_idx;
   logic [NSRC-1:0]  r_grant;
   logic             r_grant_start;
   logic [LED_W-1:0] r_led;

   logic             w_pick_valid;
   logic [1:0]       w_pick_idx;
   logic [LED_W-1:0] w_src [NSRC];
   logic             w_preempt;
   logic             w_expire;
   logic             w_release;
   logic             w_exit;
   logic             w_enter_show;

   led_rr_pick u_pick (
      .i_req       (bus.src_req),
      .i_last_idx  (r_last_idx),
      .i_force_en  (bus.force_en),
      .i_force_sel (bus.force_sel),
      .o_valid     (w_pick_valid),
      .o_idx       (w_pick_idx)
   );

   for (genvar i = 0; i < NSRC; i++) begin : g_src
      assign w_src[i] = bus.src_led[i*LED_W +: LED_W];
   end

   // Exit causes while showing; any of them ends the current grant.
   assign w_preempt = bus.force_en && (bus.force_sel != r_idx);
   assign w_expire  = (r_cnt == '0) && !bus.hold;
   assign w_release = !bus.force_en && !bus.src_req[r_idx];
   assign w_exit    = w_preempt || w_expire || w_release;

   // A grant starts when blanking ends with a pick, when leaving IDLE or
   // SHOW without a blank gap, or when the same source is renewed.
   always_comb begin
      w_enter_show = 1'b0;
      case (r_state)
         IDLE:    w_enter_show = w_pick_valid && NO_BLANK;
         BLANK:   w_enter_show = (r_cnt == '0) && w_pick_valid;
         SHOW:    w_enter_show = w_exit && w_pick_valid &&
                                 ((w_pick_idx == r_idx) || NO_BLANK);
         default: w_enter_show = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_last_idx    <= 2'd3;
         r_idx         <= 2'd0;
         r_grant       <= '0;
         r_grant_start <= 1'b0;
         r_led         <= '0;
      end else begin
         r_grant_start <= 1'b0;
         case (r_state)
            IDLE: begin
               r_led   <= '0;
               r_grant <= '0;
               if (w_pick_valid) begin
                  r_state <= BLANK;
                  r_cnt   <= BLANK_LD;
               end
            end
            BLANK: begin
               r_led   <= '0;
               r_grant <= '0;
               if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
               else if (!w_pick_valid) r_state <= IDLE;
            end
            SHOW: begin
               if (w_exit) begin
                  r_led   <= '0;
                  r_grant <= '0;
                  r_state <= w_pick_valid ? BLANK : IDLE;
                  r_cnt   <= w_pick_valid ? BLANK_LD : '0;
               end else begin
                  r_led <= w_src[r_idx];
                  if (!bus.hold && (r_cnt != '0)) r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_led   <= '0;
               r_grant <= '0;
            end
         endcase
         // Grant entry overrides the transitions above.
         if (w_enter_show) begin
            r_state       <= SHOW;
            r_cnt         <= DWELL_LD;
            r_idx         <= w_pick_idx;
            r_last_idx    <= w_pick_idx;
            r_grant       <= onehot4(w_pick_idx);
            r_grant_start <= 1'b1;
            r_led         <= w_src[w_pick_idx];
         end
      end
   end

   assign bus.grant       = r_grant;
   assign bus.grant_start = r_grant_start;
   assign bus.active_idx  = r_idx;
   assign bus.led         = r_led;
   assign bus.busy        = (r_state != IDLE);
   assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_led_scheduler.sv
// tb_led_scheduler: directed bench for led_scheduler with DWELL_CYC=8,
// BLANK_CYC=2. Each stimulus step queues the expected outputs for that cycle;
// a negedge monitor pops and compares them.
// Expected word: [15] busy [14] grant_start [13:10] grant [9:8] idx [7:0] led
module tb_led_scheduler;
   import led_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   led_scheduler_if bus();

   led_scheduler #(.DWELL_CYC(8), .BLANK_CYC(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [15:0] exp_q[$];
   string       tag_q[$];
   int          checks = 0;
   int          errors = 0;

   // src < 0 means no grant expected.
   function automatic logic [15:0] v(input bit busy, input bit gs,
                                     input int src, input logic [7:0] led);
      logic [3:0] g;
      logic [1:0] idx;
      g   = 4'd0;
      idx = 2'd0;
      if (src >= 0) begin
         idx    = src[1:0];
         g[idx] = 1'b1;
      end
      return {busy, gs, g, idx, led};
   endfunction

   localparam logic [15:0] IDLE_V = 16'h0000;
   localparam logic [15:0] BLK_V  = 16'h8000;

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [15:0] e;
      logic [15:0] a;
      string       t;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         a = {bus.busy, bus.grant_start, bus.grant,
              (e[13:10] != 4'd0) ? bus.active_idx : 2'd0, bus.led};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s @%0t: got busy=%b gs=%b grant=%b idx=%0d led=%h, want busy=%b gs=%b grant=%b idx=%0d led=%h",
                     t, $time, a[15], a[14], a[13:10], a[9:8], a[7:0],
                     e[15], e[14], e[13:10], e[9:8], e[7:0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input logic [15:0] e, input string tag);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
   endtask

   task automatic show_run(input int src, input logic [7:0] led, input int n,
                           input bit first_gs, input string tag);
      for (int i = 0; i < n; i++) step(v(1'b1, first_gs && (i == 0), src, led), tag);
   endtask

   task automatic blanks(input int n, input string tag);
      for (int i = 0; i < n; i++) step(BLK_V, tag);
   endtask

   task automatic idles(input int n, input string tag);
      for (int i = 0; i < n; i++) step(IDLE_V, tag);
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.src_req   = 4'd0;
      bus.hold      = 1'b0;
      bus.force_en  = 1'b0;
      bus.force_sel = 2'd0;
      idles(2, "reset");
      rst_n = 1'b1;
      idles(1, "reset_release");
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n         = 1'b0;
      bus.src_req   = 4'd0;
      bus.src_led   = 32'h44332211;
      bus.hold      = 1'b0;
      bus.force_en  = 1'b0;
      bus.force_sel = 2'd0;
      @(posedge clk);
      #1;

      // 1. reset and idle
      do_reset();
      idles(20, "idle");

      // 2. round robin between sources 0 and 2
      do_reset();
      bus.src_req = 4'b0101;
      idles(1, "rr_start");
      blanks(2, "rr_blank0");
      show_run(0, 8'h11, 8, 1'b1, "rr_show0");
      blanks(2, "rr_blank2");
      show_run(2, 8'h33, 8, 1'b1, "rr_show2");
      blanks(2, "rr_blank0b");
      show_run(0, 8'h11, 8, 1'b1, "rr_show0b");

      // 3. single requester renews without blanking
      do_reset();
      bus.src_req = 4'b0010;
      idles(1, "single_start");
      blanks(2, "single_blank");
      for (int r = 0; r < 3; r++) show_run(1, 8'h22, 8, 1'b1, "single_show");

      // 4a. hold for 5 cycles stretches SHOW to 13 cycles
      do_reset();
      bus.src_req = 4'b0101;
      idles(1, "hold_start");
      blanks(2, "hold_blank");
      show_run(0, 8'h11, 2, 1'b1, "hold_pre");
      bus.hold = 1'b1;
      show_run(0, 8'h11, 5, 1'b0, "hold_on");
      bus.hold = 1'b0;
      show_run(0, 8'h11, 6, 1'b0, "hold_post");
      blanks(2, "hold_blank2");
      // 4b. early release of source 2 after 4 SHOW cycles
      show_run(2, 8'h33, 3, 1'b1, "rel_pre");
      bus.src_req = 4'b0001;
      show_run(2, 8'h33, 1, 1'b0, "rel_last");
      blanks(2, "rel_blank");
      show_run(0, 8'h11, 8, 1'b1, "rel_show0");

      // 5. force preemption to a non-requesting source
      do_reset();
      bus.src_req = 4'b0001;
      idles(1, "force_start");
      blanks(2, "force_blank0");
      show_run(0, 8'h11, 3, 1'b1, "force_pre");
      bus.force_en  = 1'b1;
      bus.force_sel = 2'd3;
      show_run(0, 8'h11, 1, 1'b0, "force_last");
      blanks(2, "force_blank");
      show_run(3, 8'h44, 8, 1'b1, "force_show");
      show_run(3, 8'h44, 8, 1'b1, "force_renew");
      show_run(3, 8'h44, 4, 1'b1, "force_renew2");

      // 6. asynchronous reset in the middle of SHOW of source 2
      do_reset();
      bus.src_req = 4'b0101;
      idles(1, "areset_start");
      blanks(2, "areset_blank0");
      show_run(0, 8'h11, 8, 1'b1, "areset_show0");
      blanks(2, "areset_blank2");
      show_run(2, 8'h33, 3, 1'b1, "areset_show2");
      rst_n = 1'b0;
      idles(2, "areset_low");
      rst_n = 1'b1;
      idles(1, "areset_release");
      blanks(2, "areset_blank");
      show_run(0, 8'h11, 8, 1'b1, "areset_first");

      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_scheduler.md
Name: led_scheduler

Overview:
- Time-shares the 8-LED bank between up to four pattern sources, e.g. led_wave, a binary counter and a serial-driven pattern.
- Arbitrates source requests round-robin and shows each granted source for a programmable dwell time.
- Inserts a blanking gap between different sources and supports a forced source selection.
- Sits in the top level between the pattern generators and the led[7:0] pins.

Parameters:
- NSRC, 4, number of sources; fixed at 4 for this revision, with 2-bit indices.
- DWELL_CYC, 25_000_000, clock cycles a granted source is displayed (0.5 s at 50 MHz); must be >= 1.
- BLANK_CYC, 1_000_000, clock cycles the LEDs are forced off between different sources; 0 skips blanking.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- src_req  input  4  per-source display request, level-sensitive.
- src_led  input  32  packed source patterns; source i occupies [8i+7:8i].
- hold  input  1  freezes the dwell counter while high.
- force_en  input  1  overrides arbitration with force_sel.
- force_sel  input  2  forced source index.
- grant  output  4  one-hot grant to the displayed source; zero when none.
- grant_start  output  1  one-cycle pulse on each new or renewed grant.
- active_idx  output  2  index of the granted source (valid when grant != 0).
- led  output  8  registered LED drive.
- busy  output  1  high in BLANK or SHOW.

Behaviour:
- Clock and reset:
  - Single clock.
  - Reset is asynchronous and active-low on rst_n.
- Reset state:
  - state=IDLE, led=0, grant=0, grant_start=0, active_idx=0, busy=0.
  - Counter=0, last_idx=3, so the first round-robin pick is source 0.
- Pick function:
  - If force_en=1, pick=force_sel, whether or not it is requesting.
  - Otherwise pick is the first requesting index after last_idx, modulo 4.
  - "none" when force_en=0 and src_req=0.
- State machine IDLE / BLANK / SHOW:
  - IDLE:
    - led=0.
    - If pick exists: go to BLANK and load counter=BLANK_CYC-1.
    - If BLANK_CYC=0, go directly to SHOW.
  - BLANK:
    - led=0, grant=0.
    - Counter decrements each cycle.
    - At 0: go to SHOW with the pick re-evaluated in that cycle.
    - If pick is none at that point: go to IDLE.
  - SHOW entry:
    - grant=onehot(idx), active_idx=idx, last_idx=idx.
    - Counter=DWELL_CYC-1, grant_start=1 for exactly one cycle.
  - SHOW:
    - led <= src_led[8*idx +: 8] every cycle, giving 1-cycle latency from src_led to led.
    - Counter decrements unless hold=1.
    - Leave SHOW when the counter reaches 0 with hold=0.
    - Early release: also leave when src_req[idx] drops and force_en=0.
  - SHOW exit:
    - Compute the next pick.
    - If next == idx: stay in SHOW, reload the counter, pulse grant_start again, no blank.
    - If next is a different source: go to BLANK.
    - If none: go to IDLE, with grant=0 and led=0 on the next cycle.
- Force preemption:
  - Applies in SHOW when force_en=1 and force_sel != idx.
  - The exit is taken immediately (next cycle in BLANK), ignoring the dwell count and hold.
  - During BLANK, force_sel changes are absorbed by the re-evaluation at the end of BLANK.
- Simultaneous events:
  - Priority for the SHOW exit cause: force preemption > dwell expiry > early release.
  - A src_req rising in the same cycle as an exit is included in the pick.
  - Dwell expiry with hold=1 is deferred until hold falls.
- busy: busy = (state != IDLE).
- Reset mid-operation: returns all registers to their reset values immediately, within the same cycle (asynchronous); no grant_start pulse on reset.
- Counter width: $clog2(max(DWELL_CYC, BLANK_CYC) + 1); no wrap; it only ever decrements from a loaded value to 0.

Decomposition:
- Package led_pkg:
  - NSRC and LED_W=8 constants.
  - State enum {IDLE, BLANK, SHOW}.
  - onehot4 function.
- Sub-module led_rr_pick: combinational round-robin picker.
  - Inputs: req[3:0], last_idx, force_en, force_sel.
  - Outputs: valid, idx.
- led_scheduler holds the FSM, counter and output registers.

Test Plan:
All tests use DWELL_CYC=8 and BLANK_CYC=2.
1. Reset and idle: rst_n=0 then 1 with src_req=0 -> led=0, grant=0, busy=0 for 20 cycles.
2. Round robin: src_req=4'b0101, src_led bytes 0x11/0x22/0x33/0x44.
   - Expect 2 blank cycles, then grant=0001 with led=0x11 for 8 cycles.
   - Then 2 blank cycles, then grant=0100 with led=0x33 for 8 cycles, repeating.
   - grant_start pulses once per grant.
3. Single requester: src_req=4'b0010 -> grant=0010 continuously, no blank gaps, grant_start pulses every 8 cycles.
4. Hold and early release:
   - hold=1 for 5 cycles mid-SHOW -> the SHOW period stretches to 13 cycles.
   - Dropping src_req[idx] mid-SHOW -> exit to BLANK on the next cycle.
5. Force:
   - During SHOW of source 0, set force_en=1 and force_sel=3 with src_req[3]=0.
   - Expect the next cycle in BLANK, then grant=1000 and led=0x44, held indefinitely while force_en=1.
6. Async reset mid-SHOW: rst_n low between clock edges -> led=0 and grant=0 before the next clk edge; after release, the first grant is source 0.
